// File: rtl/watch_time_set_pkg.sv
// rtl/watch_time_set_pkg.sv - shared types and field limits for the watch time-set controller
package watch_pkg;

  // Edit state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MT = 2'd2,
    ST_SET_MU = 2'd3
  } state_t;

  // Field widths
  localparam int HH_W = 5;
  localparam int MT_W = 3;
  localparam int MU_W = 4;

  // Largest legal value of each field; the next increment wraps to 0
  localparam logic [HH_W-1:0] HH_MAX = 5'd23;
  localparam logic [MT_W-1:0] MT_MAX = 3'd5;
  localparam logic [MU_W-1:0] MU_MAX = 4'd9;

  // Blank-mask bit positions, one per display digit
  localparam int BLANK_HXXX = 3;
  localparam int BLANK_XHXX = 2;
  localparam int BLANK_XXMX = 1;
  localparam int BLANK_XXXM = 0;

endpackage

// File: rtl/watch_time_set_button_debounce.sv
// rtl/watch_time_set_button_debounce.sv - synchronizer, stable-level debouncer and press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYC = 655
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronize, accept a new level after DEBOUNCE_CYC matching cycles, pulse on its rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/watch_time_set.sv
// rtl/watch_time_set.sv - button-driven HH:MM edit controller with commit strobe and blink mask
module watch_time_set
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 655,
  parameter int TIMEOUT_CYC  = 327680,
  parameter int BLINK_DIV    = 16384
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            bt0_i,
  input  logic            bt1_i,
  input  logic [HH_W-1:0] cur_hh_i,
  input  logic [MT_W-1:0] cur_mt_i,
  input  logic [MU_W-1:0] cur_mu_i,
  output logic [HH_W-1:0] cfg_hhxx_o,
  output logic [MT_W-1:0] cfg_xxmx_o,
  output logic [MU_W-1:0] cfg_xxxm_o,
  output logic            load_o,
  output logic            editing_o,
  output logic [3:0]      blank_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic            p0;
  logic            p1;
  state_t          state;
  logic [HH_W-1:0] hh;
  logic [MT_W-1:0] mt;
  logic [MU_W-1:0] mu;
  logic [TW-1:0]   to_cnt;
  logic [BW-1:0]   bl_cnt;
  logic            ph;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_bt0 (
    .clk   (clk_i),
    .rst   (rst_i),
    .raw   (bt0_i),
    .press (p0)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_bt1 (
    .clk   (clk_i),
    .rst   (rst_i),
    .raw   (bt1_i),
    .press (p1)
  );

  // Edit FSM: field capture/increment, commit with load strobe, inactivity abort, blink phase
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      hh         <= '0;
      mt         <= '0;
      mu         <= '0;
      cfg_hhxx_o <= '0;
      cfg_xxmx_o <= '0;
      cfg_xxxm_o <= '0;
      load_o     <= 1'b0;
      editing_o  <= 1'b0;
      to_cnt     <= '0;
      bl_cnt     <= '0;
      ph         <= 1'b0;
    end else begin
      load_o <= 1'b0;
      if (state == ST_IDLE) begin
        to_cnt <= '0;
        bl_cnt <= '0;
        ph     <= 1'b0;
        if (p0) begin
          state     <= ST_SET_HH;
          editing_o <= 1'b1;
          hh        <= (cur_hh_i > HH_MAX) ? '0 : cur_hh_i;
          mt        <= (cur_mt_i > MT_MAX) ? '0 : cur_mt_i;
          mu        <= (cur_mu_i > MU_MAX) ? '0 : cur_mu_i;
        end
      end else if (p0) begin
        // bt0 wins over a coincident bt1 press
        to_cnt <= '0;
        bl_cnt <= '0;
        ph     <= 1'b0;
        case (state)
          ST_SET_HH: state <= ST_SET_MT;
          ST_SET_MT: state <= ST_SET_MU;
          default: begin
            state      <= ST_IDLE;
            editing_o  <= 1'b0;
            cfg_hhxx_o <= hh;
            cfg_xxmx_o <= mt;
            cfg_xxxm_o <= mu;
            load_o     <= 1'b1;
          end
        endcase
      end else if (p1) begin
        to_cnt <= '0;
        bl_cnt <= '0;
        ph     <= 1'b0;
        case (state)
          ST_SET_HH: hh <= (hh == HH_MAX) ? '0 : hh + HH_W'(1);
          ST_SET_MT: mt <= (mt == MT_MAX) ? '0 : mt + MT_W'(1);
          default:   mu <= (mu == MU_MAX) ? '0 : mu + MU_W'(1);
        endcase
      end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state     <= ST_IDLE;
        editing_o <= 1'b0;
        to_cnt    <= '0;
        bl_cnt    <= '0;
        ph        <= 1'b0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
        if (bl_cnt == BW'(BLINK_DIV - 1)) begin
          bl_cnt <= '0;
          ph     <= ~ph;
        end else begin
          bl_cnt <= bl_cnt + BW'(1);
        end
      end
    end
  end

  // Blank the digit(s) under edit during the blink phase
  always_comb begin
    blank_o = '0;
    case (state)
      ST_SET_HH: begin
        blank_o[BLANK_HXXX] = ph;
        blank_o[BLANK_XHXX] = ph;
      end
      ST_SET_MT: blank_o[BLANK_XXMX] = ph;
      ST_SET_MU: blank_o[BLANK_XXXM] = ph;
      default:   blank_o = '0;
    endcase
  end

endmodule

// File: tb/tb_watch_time_set.sv
// tb/tb_watch_time_set.sv - scoreboard bench for watch_time_set with randomized button sequences
module tb_watch_time_set;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       bt0_i = 1'b0;
  logic       bt1_i = 1'b0;
  logic [4:0] cur_hh_i = '0;
  logic [2:0] cur_mt_i = '0;
  logic [3:0] cur_mu_i = '0;
  logic [4:0] cfg_hhxx_o;
  logic [2:0] cfg_xxmx_o;
  logic [3:0] cfg_xxxm_o;
  logic       load_o;
  logic       editing_o;
  logic [3:0] blank_o;

  watch_time_set #(.DEBOUNCE_CYC(4), .TIMEOUT_CYC(200), .BLINK_DIV(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .bt0_i      (bt0_i),
    .bt1_i      (bt1_i),
    .cur_hh_i   (cur_hh_i),
    .cur_mt_i   (cur_mt_i),
    .cur_mu_i   (cur_mu_i),
    .cfg_hhxx_o (cfg_hhxx_o),
    .cfg_xxmx_o (cfg_xxmx_o),
    .cfg_xxxm_o (cfg_xxxm_o),
    .load_o     (load_o),
    .editing_o  (editing_o),
    .blank_o    (blank_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hh;
    int mt;
    int mu;
  } tval_t;

  tval_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  load_prev = 1'b0;

  // Reference model: 0 = idle, 1 = hours, 2 = tens of minutes, 3 = units of minutes
  int m_mode = 0;
  int m_hh = 0, m_mt = 0, m_mu = 0;
  int c_hh = 0, c_mt = 0, c_mu = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_press(input bit b0, input bit b1);
    tval_t t;
    if (b0) begin
      if (m_mode == 0) begin
        m_hh = (int'(cur_hh_i) > 23) ? 0 : int'(cur_hh_i);
        m_mt = (int'(cur_mt_i) > 5) ? 0 : int'(cur_mt_i);
        m_mu = (int'(cur_mu_i) > 9) ? 0 : int'(cur_mu_i);
        m_mode = 1;
      end else if (m_mode == 3) begin
        m_mode = 0;
        c_hh = m_hh; c_mt = m_mt; c_mu = m_mu;
        t.hh = m_hh; t.mt = m_mt; t.mu = m_mu;
        exp_q.push_back(t);
      end else begin
        m_mode++;
      end
    end else if (b1) begin
      if (m_mode == 1) m_hh = (m_hh + 1) % 24;
      else if (m_mode == 2) m_mt = (m_mt + 1) % 6;
      else if (m_mode == 3) m_mu = (m_mu + 1) % 10;
    end
  endfunction

  task automatic press(input bit b0, input bit b1, input bit bounce);
    model_press(b0, b1);
    if (bounce) begin
      repeat (2) begin
        bt0_i = b0; bt1_i = b1;
        tick(1 + $urandom_range(0, 1));
        bt0_i = 1'b0; bt1_i = 1'b0;
        tick(1);
      end
    end
    bt0_i = b0; bt1_i = b1;
    tick(10);
    bt0_i = 1'b0; bt1_i = 1'b0;
    tick(12);
  endtask

  task automatic check_state(input string tag);
    logic [3:0] allowed;
    check({tag, "_editing"}, int'(editing_o), (m_mode != 0) ? 1 : 0);
    check({tag, "_cfg_hh"}, int'(cfg_hhxx_o), c_hh);
    check({tag, "_cfg_mt"}, int'(cfg_xxmx_o), c_mt);
    check({tag, "_cfg_mu"}, int'(cfg_xxxm_o), c_mu);
    case (m_mode)
      1: allowed = 4'b1100;
      2: allowed = 4'b0010;
      3: allowed = 4'b0001;
      default: allowed = 4'b0000;
    endcase
    check({tag, "_blank_mask"}, int'(blank_o & ~allowed), 0);
  endtask

  // Monitor: every load strobe must match the oldest pending commit and last one cycle
  always @(negedge clk) begin
    if (!rst_i && load_o) begin
      tval_t e;
      check("load_single_cycle", int'(load_prev), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_load", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("load_hh", int'(cfg_hhxx_o), e.hh);
        check("load_mt", int'(cfg_xxmx_o), e.mt);
        check("load_mu", int'(cfg_xxxm_o), e.mu);
      end
    end
    load_prev = load_o;
  end

  initial begin
    int n;
    int run;

    tick(3);
    check("rst_cfg_hh", int'(cfg_hhxx_o), 0);
    check("rst_cfg_mt", int'(cfg_xxmx_o), 0);
    check("rst_cfg_mu", int'(cfg_xxxm_o), 0);
    check("rst_load", int'(load_o), 0);
    check("rst_editing", int'(editing_o), 0);
    check("rst_blank", int'(blank_o), 0);
    rst_i = 1'b0;
    tick(2);

    // Short glitch must not register as a press
    bt0_i = 1'b1; tick(3); bt0_i = 1'b0; tick(20);
    check("short_glitch_editing", int'(editing_o), 0);

    // Wrap-around of all three fields
    cur_hh_i = 5'd23; cur_mt_i = 3'd5; cur_mu_i = 4'd9;
    press(1, 0, 0);
    press(0, 1, 0); press(1, 0, 0);
    press(0, 1, 0); press(1, 0, 0);
    press(0, 1, 0); press(1, 0, 0);
    check_state("wrap");

    // Entry latency: editing registers the cycle after the press pulse
    cur_hh_i = 5'd9; cur_mt_i = 3'd4; cur_mu_i = 4'd1;
    model_press(1, 0);
    bt0_i = 1'b1;
    n = 0;
    while (!editing_o && n < 30) begin
      tick(1);
      n++;
    end
    check("entry_latency", n, 8);
    tick(2); bt0_i = 1'b0; tick(12);

    // Blink period in hours edit
    n = 0;
    while (blank_o != 4'b0000 && n < 40) begin tick(1); n++; end
    n = 0;
    while (blank_o != 4'b1100 && n < 40) begin tick(1); n++; end
    check("blink_seen", int'(blank_o), 12);
    run = 0;
    while (blank_o == 4'b1100 && run < 40) begin tick(1); run++; end
    check("blink_on_len", run, 8);
    run = 0;
    while (blank_o == 4'b0000 && run < 40) begin tick(1); run++; end
    check("blink_off_len", run, 8);

    // Normal edit 09:41 -> 12:41, one press bounces
    press(0, 1, 0); press(0, 1, 1); press(0, 1, 0);
    check_state("normal_sethh");
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    check_state("normal_commit");

    // Inactivity abort in tens-of-minutes edit
    cur_hh_i = 5'd3; cur_mt_i = 3'd2; cur_mu_i = 4'd7;
    press(1, 0, 0); press(1, 0, 0);
    tick(150);
    check("timeout_not_early", int'(editing_o), 1);
    tick(100);
    m_mode = 0;
    check_state("timeout");

    // Simultaneous presses: bt0 acts, hours untouched
    cur_hh_i = 5'd7; cur_mt_i = 3'd1; cur_mu_i = 4'd2;
    press(1, 0, 0);
    press(1, 1, 0);
    check_state("simul");
    press(1, 0, 0); press(1, 0, 0);
    check_state("simul_commit");

    // Reset mid-edit
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    check_state("pre_reset");
    rst_i = 1'b1; tick(1); rst_i = 1'b0;
    m_mode = 0; c_hh = 0; c_mt = 0; c_mu = 0;
    check("midrst_load", int'(load_o), 0);
    check_state("midrst");
    press(0, 1, 0);
    check_state("midrst_bt1");

    // Randomized sequences, including out-of-range captures and bounce
    for (int i = 0; i < 80; i++) begin
      int r;
      bit b0, b1;
      cur_hh_i = 5'($urandom_range(0, 31));
      cur_mt_i = 3'($urandom_range(0, 7));
      cur_mu_i = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      b0 = (r < 40) || (r >= 90);
      b1 = (r >= 40);
      press(b0, b1, ($urandom_range(0, 2) == 0));
      check_state("rand");
    end

    // Drain any open edit so every expected commit is observed
    while (m_mode != 0) press(1, 0, 0);
    tick(5);
    check_state("final");
    check("pending_loads", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_time_set.md
Name: watch_time_set

Overview:
- Button-driven time-setting controller for the HH:MM watch; the input side of the display path.
- Debounces two raw push-buttons and runs an edit state machine that walks hours, tens-of-minutes and units-of-minutes.
- Produces the initial-value buses (cfg_hhxx/cfg_xxmx/cfg_xxxm) plus a one-cycle load strobe consumed by the hour/minute counters.
- Drives a per-digit blank mask so the digit under edit blinks on the 7-segment displays.

Parameters:
DEBOUNCE_CYC, 655, consecutive stable cycles required to accept a button level change (~20 ms at 32.768 kHz)
TIMEOUT_CYC, 327680, inactivity cycles in an edit state before abort (10 s)
BLINK_DIV, 16384, cycles per blink half-period (0.5 s)

Ports:
clk_i  in  1  32.768 kHz clock
rst_i  in  1  reset, synchronous, active-high
bt0_i  in  1  raw mode/select button, active-high, asynchronous to clk_i
bt1_i  in  1  raw increment button, active-high, asynchronous
cur_hh_i  in  5  current hours (0-23), sampled on edit entry
cur_mt_i  in  3  current tens of minutes (0-5)
cur_mu_i  in  4  current units of minutes (0-9)
cfg_hhxx_o  out  5  committed hours
cfg_xxmx_o  out  3  committed tens of minutes
cfg_xxxm_o  out  4  committed units of minutes
load_o  out  1  one-cycle strobe: cfg_* valid, counters must load
editing_o  out  1  high in any SET state
blank_o  out  4  blank mask; [3]=hxxx, [2]=xhxx, [1]=xxmx, [0]=xxxm

Behaviour:
- Reset (any cycle, including mid-edit): state IDLE; cfg_* = 0; load_o = 0; editing_o = 0; blank_o = 0; debounced levels low; all counters 0. No load is issued on abort.
- Input conditioning, per button:
  - 2-FF synchronizer feeds the debouncer.
  - Debounced level changes only after the synchronized input has held the new level for DEBOUNCE_CYC consecutive cycles; any mismatch restarts the count.
  - Press pulse = one-cycle rising edge of the debounced level.
  - Latency: press pulse asserts exactly DEBOUNCE_CYC+3 cycles after the first raw-high cycle.
  - A held button yields one press only; there is no autorepeat. Release generates no event.
- FSM states: IDLE, SET_HH, SET_MT, SET_MU.
  - IDLE: bt0 press -> SET_HH and capture cur_* into the edit registers. Any captured field out of range (hh>23, mt>5, mu>9) is captured as 0. bt1 is ignored.
  - SET_HH: bt1 press -> hh = (hh==23) ? 0 : hh+1. bt0 press -> SET_MT.
  - SET_MT: bt1 press -> mt = (mt==5) ? 0 : mt+1. bt0 press -> SET_MU.
  - SET_MU: bt1 press -> mu = (mu==9) ? 0 : mu+1. bt0 press -> IDLE; cfg_* <= edit registers and load_o = 1 in the same cycle the new cfg values appear (registered), then 0.
  - Simultaneous bt0 and bt1 press in the same cycle: bt0 acts, bt1 is discarded.
- Timeout:
  - The inactivity counter clears on state entry and on every press.
  - When it reaches TIMEOUT_CYC in a SET state -> IDLE with no load; cfg_* unchanged.
- editing_o is registered and equals (state != IDLE).
- Blink:
  - A phase bit toggles every BLINK_DIV cycles.
  - The phase counter and phase bit clear to 0 (digits visible) on every state entry and after every increment.
  - blank_o: SET_HH = {ph,ph,0,0}; SET_MT = {0,0,ph,0}; SET_MU = {0,0,0,ph}; IDLE = 0.
- All arithmetic stays at the field width; there is no carry between fields.

Decomposition:
- Package watch_pkg:
  - FSM state encoding (2-bit).
  - Field limits HH_MAX=23, MT_MAX=5, MU_MAX=9.
  - Field widths 5/3/4.
  - Blank-mask bit indices.
- Sub-module button_debounce (synchronizer + stable counter + rising-edge pulse), parameterized by DEBOUNCE_CYC and instantiated once per button.

Test Plan (DEBOUNCE_CYC=4, TIMEOUT_CYC=200, BLINK_DIV=8):
- Debounce: bt0 high 3 cycles then low -> no press, editing_o stays 0. bt0 high 10 cycles -> editing_o=1 registered after the press pulse at cycle 7; 4 raw toggles during bounce -> exactly one press.
- Wrap: cur=23/5/9. Enter, then bt1, bt0, bt1, bt0, bt1, bt0 -> load_o high exactly one cycle; cfg_hhxx=0, cfg_xxmx=0, cfg_xxxm=0.
- Normal edit: cur=09/4/1. Enter, bt1 x3, bt0, bt0, bt0 -> cfg_hhxx=12, cfg_xxmx=4, cfg_xxxm=1, one load pulse. blank_o toggles {1,1,0,0} every 8 cycles in SET_HH.
- Timeout: enter SET_MT, no presses for 200 cycles -> editing_o=0, blank_o=0, load_o never asserted, cfg_* unchanged from prior commit.
- Simultaneous: in SET_HH with hh=7, bt0 and bt1 presses aligned to the same cycle -> state SET_MT, hh remains 7.
- Reset mid-edit: rst_i asserted one cycle in SET_MU -> next cycle cfg_*=0, editing_o=0, blank_o=0, load_o=0; a following bt1 press has no effect.
